jk_mod_counter: RTL and testbench

Synchronous modulo-N up/down counter built as a bank of JK flip-flop cells plus the excitation logic that drives their J/K inputs. It sits directly upstream of the JK storage cells: each cycle it computes the required next count and translates it into per-bit J/K commands (hold, clear, set, toggle). Used as the general-purpose event/divider counter in the sequential-logic library.

---
 rtl/jk_pkg.sv | 25 ++
 rtl/jk_cell.sv | 30 +++
 rtl/jk_mod_counter.sv | 87 ++++++++
 tb/tb_jk_mod_counter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions: the {j,k} command encoding and the
// excitation function that picks a command from the present and next value.
package jk_pkg;

  // Encoded as {j,k}, so a command drives a JK cell's inputs directly.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_CLEAR  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_t;

  // Excitation for one bit. Uses SET/CLEAR rather than TOGGLE where the bit
  // flips, so that each cell's command depends only on the bit's target value.
  function automatic jk_cmd_t jk_excite(input logic q, input logic n);
    if (q == n) begin
      return JK_HOLD;
    end else if (n) begin
      return JK_SET;
    end else begin
      return JK_CLEAR;
    end
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop with synchronous active-low reset.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  // JK update: hold, clear, set or toggle according to {j,k}.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD:   q <= q;
        JK_CLEAR:  q <= 1'b0;
        JK_SET:    q <= 1'b1;
        JK_TOGGLE: q <= ~q;
        default:   q <= q;
      endcase
    end
  end

  assign q_bar = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter built from WIDTH JK cells. Each cycle the
// next count is computed, then translated into per-bit J/K commands.
// Optional build macro: JK_MOD_COUNTER_SATURATE_EN -- the counter sticks at
// its terminal value instead of wrapping, and wrapped is tied to 0.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_bar;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             at_zero;
  logic             at_max;

  // Zero detect straight off the inverted cell outputs.
  assign at_zero = &q_bar;
  assign at_max  = (count == MAX_VAL);

  // Terminal count: the step about to be taken would leave the range.
  assign tc = en & (up ? at_max : at_zero);

  // Next count: load (clamped) beats stepping; terminal steps wrap or hold.
  always_comb begin
    nxt = count;
    if (load) begin
      nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (tc) begin
`ifdef JK_MOD_COUNTER_SATURATE_EN
      nxt = count;
`else
      nxt = up ? '0 : MAX_VAL;
`endif
    end else if (en) begin
      nxt = up ? (count + 1'b1) : (count - 1'b1);
    end
  end

  // Per-bit excitation from present and next value.
  always_comb begin
    j_vec = '0;
    k_vec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j_vec[i], k_vec[i]} = jk_excite(count[i], nxt[i]);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (j_vec[i]),
      .k     (k_vec[i]),
      .q     (count[i]),
      .q_bar (q_bar[i])
    );
  end

`ifdef JK_MOD_COUNTER_SATURATE_EN
  assign wrapped = 1'b0;
`else
  // One-cycle pulse after a wrapping edge; a load on the same edge suppresses it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrapped <= 1'b0;
    end else begin
      wrapped <= tc & ~load;
    end
  end
`endif

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter (WIDTH=4, MODULUS=10). A behavioural
// model predicts {wrapped,count} for each edge into a queue; results are
// popped and compared #1 after the edge. tc is checked before each edge.
module tb_jk_mod_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;
  localparam int W       = WIDTH + 1;

`ifdef JK_MOD_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrapped;

  logic [W-1:0] exp_q[$];
  int n_cmp;
  int n_bad;
  int m_count;
  bit m_valid;
  int m_wraps;

  jk_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .wrapped  (wrapped)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict, clock, then compare.
  task automatic step(input bit r, input bit e, input bit u, input bit l, input int lv);
    int nxt;
    bit w;
    logic [W-1:0] exp;
    reset    = r;
    en       = e;
    up       = u;
    load     = l;
    load_val = WIDTH'(lv);
    #1;
    if (m_valid)
      check_eq("tc", {31'b0, tc},
               {31'b0, e && (u ? (m_count == MODULUS - 1) : (m_count == 0))});
    nxt = m_count;
    w   = 1'b0;
    if (!r) begin
      nxt = 0;
    end else if (l) begin
      nxt = (lv > MODULUS - 1) ? MODULUS - 1 : lv;
    end else if (e && u) begin
      if (m_count == MODULUS - 1) begin
        nxt = SAT ? m_count : 0;
        w   = !SAT;
      end else begin
        nxt = m_count + 1;
      end
    end else if (e && !u) begin
      if (m_count == 0) begin
        nxt = SAT ? 0 : MODULUS - 1;
        w   = !SAT;
      end else begin
        nxt = m_count - 1;
      end
    end
    m_count = nxt;
    if (w) m_wraps++;
    exp_q.push_back({w, WIDTH'(nxt)});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check_eq("count", {28'b0, count}, {28'b0, exp[WIDTH-1:0]});
    check_eq("wrapped", {31'b0, wrapped}, {31'b0, exp[WIDTH]});
    m_valid = 1'b1;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    m_count  = 0;
    m_valid  = 1'b0;
    m_wraps  = 0;
    reset    = 1'b0;
    en       = 1'b1;
    up       = 1'b1;
    load     = 1'b0;
    load_val = '0;
    @(negedge clk);

    // Reset held with en=1, up=1.
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    // Twelve enabled up edges: 1..9,0,1,2 with one wrap pulse.
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 0);
    // Down count from 0 through the wrap.
    step(1, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    // Out-of-range load clamps, en ignored.
    step(1, 1, 1, 1, 13);
    step(1, 0, 1, 0, 0);
    // Reset overrides a pending load.
    step(1, 0, 0, 1, 7);
    step(0, 1, 1, 1, 3);
    // en 1,0,1 with direction flipping from 5.
    step(1, 0, 0, 1, 5);
    step(1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    // Fifteen up steps from 0 (wraps by default, sticks at 9 when saturating).
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 15; i++) step(1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    // Randomised traffic, including max load value and occasional reset.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 40) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 15));
    if (!SAT) check_eq("wraps_seen", {31'b0, m_wraps > 3}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
